mux_rr_arbiter: RTL and testbench

//   Shares one NREQ:1 data mux (built from the team's 2:1 mux cells) among NREQ requesters.

---
 rtl/mux_arb_pkg.sv | 33 +++
 rtl/mux_n1.sv | 31 +++
 rtl/mux_rr_arbiter.sv | 134 +++++++++++++
 tb/tb_mux_rr_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared arbiter package: FSM state encoding and index helpers.
// Also used by the other arbiters in the library.
package mux_arb_pkg;

   // Widest request vector the helpers accept.
   localparam int unsigned MAX_REQ   = 32;
   localparam int unsigned MAX_IDX_W = 5;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_e;

   // Binary index of the set bit of a one-hot vector (0 for an all-zero vector).
   function automatic int unsigned onehot_to_idx(input logic [MAX_REQ-1:0] oh);
      int unsigned idx;
      idx = 0;
      for (int unsigned i = 0; i < MAX_REQ; i++) begin
         if (oh[MAX_IDX_W'(i)]) begin
            idx = idx | i;
         end
      end
      return idx;
   endfunction

   // Port visited 'offset' steps after 'base' in a ring of n ports.
   function automatic int unsigned rr_index(input int unsigned base,
                                            input int unsigned offset,
                                            input int unsigned n);
      return (base + offset) % n;
   endfunction

endpackage

// File: rtl/mux_n1.sv
// NREQ:1 data mux built as a tree of 2:1 select stages.
// Leaves beyond NREQ (non power-of-two NREQ) read as zero.
module mux_n1 #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned DW   = 8,
   parameter int unsigned SELW = $clog2(NREQ)
) (
   input  logic [NREQ*DW-1:0] data_i,
   input  logic [SELW-1:0]    sel_i,
   output logic [DW-1:0]      data_o
);

   localparam int unsigned LEAVES = 1 << SELW;

   logic [DW-1:0] node [LEAVES];

   // Reduce the leaves in place, one select bit per tree level (LSB at the leaves).
   always_comb begin
      for (int unsigned i = 0; i < LEAVES; i++) begin
         node[SELW'(i)] = (i < NREQ) ? data_i[i*DW +: DW] : '0;
      end
      for (int unsigned s = 0; s < SELW; s++) begin
         for (int unsigned j = 0; j < (LEAVES >> (s + 1)); j++) begin
            node[SELW'(j)] = (((sel_i >> s) & SELW'(1)) != '0) ? node[SELW'(2*j + 1)]
                                                                : node[SELW'(2*j)];
         end
      end
      data_o = node[0];
   end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one NREQ:1 mux among NREQ requesters,
// with a valid/ready handshake toward a single consumer.
// Optional: define MUX_ARB_LOCK_EN to add the lock[NREQ] input, which keeps
// a grant across back-to-back accepted beats while lock[sel] is held.
module mux_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter  int unsigned NREQ = 4,
   parameter  int unsigned DW   = 8,
   localparam int unsigned SELW = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*DW-1:0] in_data,
`ifdef MUX_ARB_LOCK_EN
   input  logic [NREQ-1:0]   lock,
`endif
   output logic [NREQ-1:0]   ack,
   output logic [NREQ-1:0]   gnt,
   output logic [SELW-1:0]   sel,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DW-1:0]     out_data,
   output logic              busy
);

   arb_state_e      state_q, state_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [SELW-1:0] sel_q, sel_d;
   logic [SELW-1:0] last_q, last_d;
   logic            valid_q, valid_d;

   logic [NREQ-1:0] win_oh;
   logic            win_found;
   logic [SELW-1:0] win_idx;
   logic            lock_hold;
   logic [DW-1:0]   mux_data;

`ifdef MUX_ARB_LOCK_EN
   assign lock_hold = lock[sel_q];
`else
   assign lock_hold = 1'b0;
`endif

   // Round-robin pick: first requester after the last winner, wrapping around.
   always_comb begin
      win_oh    = '0;
      win_found = 1'b0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         if (!win_found && req[SELW'(rr_index(32'(last_q), k, NREQ))]) begin
            win_found = 1'b1;
            win_oh[SELW'(rr_index(32'(last_q), k, NREQ))] = 1'b1;
         end
      end
   end

   assign win_idx = SELW'(onehot_to_idx(MAX_REQ'(win_oh)));

   // Next-state logic: arbitrate in IDLE, hold the grant until accept or abort.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      last_d  = last_q;
      valid_d = valid_q;
      case (state_q)
         ST_IDLE: begin
            if (win_found) begin
               state_d = ST_GRANT;
               gnt_d   = win_oh;
               sel_d   = win_idx;
               last_d  = win_idx;
               valid_d = 1'b1;
            end
         end
         ST_GRANT: begin
            if (out_ready) begin
               if (!lock_hold) begin
                  state_d = ST_IDLE;
                  gnt_d   = '0;
                  valid_d = 1'b0;
               end
            end else if (!req[sel_q]) begin
               // Requester withdrew before the sink accepted: drop silently.
               state_d = ST_IDLE;
               gnt_d   = '0;
               valid_d = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            valid_d = 1'b0;
         end
      endcase
   end

   // State and grant registers; reset gives port 0 first priority.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         gnt_q   <= '0;
         sel_q   <= '0;
         last_q  <= SELW'(NREQ - 1);
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
         valid_q <= valid_d;
      end
   end

   mux_n1 #(
      .NREQ (NREQ),
      .DW   (DW),
      .SELW (SELW)
   ) u_mux (
      .data_i (in_data),
      .sel_i  (sel_q),
      .data_o (mux_data)
   );

   // Ack is only possible while a grant is held, so it never appears without out_valid.
   assign ack       = gnt_q & {NREQ{out_ready}};
   assign gnt       = gnt_q;
   assign sel       = sel_q;
   assign out_valid = valid_q;
   assign out_data  = valid_q ? mux_data : '0;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Testbench for mux_rr_arbiter: directed scenarios plus random traffic,
// checked cycle by cycle against a transaction-level reference model.
// Lock scenarios are exercised when MUX_ARB_LOCK_EN is defined.
module tb_mux_rr_arbiter;

   localparam int unsigned NREQ = 4;
   localparam int unsigned DW   = 8;
   localparam int unsigned SELW = $clog2(NREQ);
`ifdef MUX_ARB_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req;
   logic [NREQ*DW-1:0] in_data;
   logic [NREQ-1:0]   ack;
   logic [NREQ-1:0]   gnt;
   logic [SELW-1:0]   sel;
   logic              out_valid;
   logic              out_ready;
   logic [DW-1:0]     out_data;
   logic              busy;
`ifdef MUX_ARB_LOCK_EN
   logic [NREQ-1:0]   lock;
`endif

   mux_rr_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .in_data   (in_data),
`ifdef MUX_ARB_LOCK_EN
      .lock      (lock),
`endif
      .ack       (ack),
      .gnt       (gnt),
      .sel       (sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic            valid;
      logic [NREQ-1:0] gnt;
      logic [SELW-1:0] sel;
      logic [DW-1:0]   data;
      logic [NREQ-1:0] ack;
      logic            busy;
   } exp_t;

   exp_t            exp_q[$];
   int              dut_order[$];
   logic [DW-1:0]   din [NREQ];
   logic [DW-1:0]   nd  [NREQ];
   int              n_tests;
   int              n_fail;

   // Reference model: which port currently owns the bus, and the last winner.
   int              m_g;
   int              m_last;
   logic [NREQ-1:0] m_prev_ack;
   bit              m_stay;

   always_comb begin
      for (int i = 0; i < NREQ; i++) in_data[i*DW +: DW] = din[i];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
      end
   endtask

   task automatic model_reset();
      m_g        = -1;
      m_last     = NREQ - 1;
      m_prev_ack = '0;
      m_stay     = 1'b0;
      exp_q.delete();
      dut_order.delete();
   endtask

   // Apply one cycle of inputs, predict that cycle's outputs, advance the model.
   task automatic drive(input logic [NREQ-1:0] r, input logic rdy, input logic [NREQ-1:0] lk);
      exp_t            e;
      logic [NREQ-1:0] oh;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) din[i] = nd[i];
      req       = r;
      out_ready = rdy;
`ifdef MUX_ARB_LOCK_EN
      lock      = lk;
`endif
      oh = '0;
      if (m_g >= 0) oh[m_g] = 1'b1;
      e.valid = (m_g >= 0);
      e.gnt   = oh;
      e.sel   = (m_g >= 0) ? SELW'(m_g) : '0;
      e.data  = (m_g >= 0) ? din[m_g] : '0;
      e.ack   = rdy ? oh : '0;
      e.busy  = (m_g >= 0);
      exp_q.push_back(e);
      m_prev_ack = e.ack;
      m_stay     = 1'b0;
      if (m_g < 0) begin
         for (int k = 1; k <= NREQ; k++) begin
            if (r[(m_last + k) % NREQ]) begin
               m_g    = (m_last + k) % NREQ;
               m_last = m_g;
               break;
            end
         end
      end else if (rdy) begin
         if (LOCK_EN && lk[m_g]) m_stay = 1'b1;
         else                    m_g    = -1;
      end else if (!r[m_g]) begin
         m_g = -1;
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst       = 1'b1;
      req       = '0;
      out_ready = 1'b0;
`ifdef MUX_ARB_LOCK_EN
      lock      = '0;
`endif
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   // Monitor: compare every cycle's outputs against the predicted entry.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("out_valid", 32'(out_valid), 32'(e.valid));
         chk("gnt",       32'(gnt),       32'(e.gnt));
         chk("ack",       32'(ack),       32'(e.ack));
         chk("out_data",  32'(out_data),  32'(e.data));
         chk("busy",      32'(busy),      32'(e.busy));
         if (e.valid) chk("sel", 32'(sel), 32'(e.sel));
         if (out_valid && out_ready) dut_order.push_back(int'(sel));
      end
   end

   initial begin
      int exp_order[5];
      n_tests   = 0;
      n_fail    = 0;
      rst       = 1'b1;
      req       = '0;
      out_ready = 1'b0;
`ifdef MUX_ARB_LOCK_EN
      lock      = '0;
`endif
      for (int i = 0; i < NREQ; i++) begin
         din[i] = '0;
         nd[i]  = '0;
      end
      model_reset();

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      out_ready = 1'b1;
      #1;
      chk("rst_gnt",       32'(gnt),       32'h0);
      chk("rst_sel",       32'(sel),       32'h0);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_out_data",  32'(out_data),  32'h0);
      chk("rst_busy",      32'(busy),      32'h0);
      chk("rst_ack",       32'(ack),       32'h0);
      rst       = 1'b0;
      out_ready = 1'b0;

      // Single port
      nd[2] = 8'hA5;
      drive(4'b0100, 1'b1, '0);
      drive(4'b0100, 1'b1, '0);
      drive(4'b0000, 1'b1, '0);
      drive(4'b0000, 1'b0, '0);

      // Fairness with all ports requesting
      do_reset();
      for (int i = 0; i < NREQ; i++) nd[i] = DW'(8'h10 + i);
      for (int n = 0; n < 10; n++) drive(4'b1111, 1'b1, '0);
      @(negedge clk);
      #1;
      exp_order = '{0, 1, 2, 3, 0};
      chk("rr_order_len", 32'(dut_order.size()), 32'd5);
      for (int i = 0; i < 5 && i < dut_order.size(); i++) begin
         chk("rr_order", 32'(dut_order[i]), 32'(exp_order[i]));
      end
      drive(4'b0000, 1'b0, '0);

      // Backpressure on port 1
      nd[1] = 8'h3C;
      drive(4'b0010, 1'b0, '0);
      repeat (5) drive(4'b0010, 1'b0, '0);
      drive(4'b0010, 1'b1, '0);
      drive(4'b0000, 1'b0, '0);

      // Abort by port 3, then port 0 wins
      nd[3] = 8'h77;
      nd[0] = 8'h5A;
      drive(4'b1000, 1'b0, '0);
      drive(4'b1000, 1'b0, '0);
      drive(4'b0000, 1'b0, '0);
      dut_order.delete();
      drive(4'b0101, 1'b1, '0);
      drive(4'b0101, 1'b1, '0);
      drive(4'b0100, 1'b1, '0);
      drive(4'b0100, 1'b1, '0);
      drive(4'b0000, 1'b0, '0);
      @(negedge clk);
      #1;
      chk("abort_acks", 32'(dut_order.size()), 32'd2);
      if (dut_order.size() > 0) chk("abort_next_winner", 32'(dut_order[0]), 32'd0);

      // Asynchronous reset in the middle of a grant
      drive(4'b0001, 1'b0, '0);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      #1;
      chk("pre_rst_valid", 32'(out_valid), 32'h1);
      rst = 1'b1;
      #1;
      chk("midrst_gnt",       32'(gnt),       32'h0);
      chk("midrst_out_valid", 32'(out_valid), 32'h0);
      chk("midrst_ack",       32'(ack),       32'h0);
      chk("midrst_busy",      32'(busy),      32'h0);
      chk("midrst_out_data",  32'(out_data),  32'h0);
      req       = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      drive(4'b0001, 1'b1, '0);
      drive(4'b0001, 1'b1, '0);
      drive(4'b0000, 1'b0, '0);

`ifdef MUX_ARB_LOCK_EN
      // Locked burst from port 1, then port 2 is served
      do_reset();
      nd[1] = 8'h11;
      nd[2] = 8'h22;
      drive(4'b0110, 1'b1, 4'b0010);
      drive(4'b0110, 1'b1, 4'b0010);
      drive(4'b0110, 1'b1, 4'b0010);
      drive(4'b0110, 1'b1, 4'b0000);
      drive(4'b0100, 1'b1, 4'b0000);
      drive(4'b0100, 1'b1, 4'b0000);
      drive(4'b0000, 1'b0, 4'b0000);
      @(negedge clk);
      #1;
      chk("lock_acks", 32'(dut_order.size()), 32'd4);
      for (int i = 0; i < 4 && i < dut_order.size(); i++) begin
         chk("lock_order", 32'(dut_order[i]), (i < 3) ? 32'd1 : 32'd2);
      end
`endif

      // Random traffic obeying the requester protocol
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         logic [NREQ-1:0] r;
         logic            rdy;
         logic [NREQ-1:0] lk;
         r   = req;
         rdy = ($urandom_range(0, 9) < 6);
         lk  = NREQ'($urandom);
         for (int i = 0; i < NREQ; i++) begin
            if (m_prev_ack[i] && !(m_stay && m_g == i)) begin
               r[i] = 1'b0;
            end else if (!r[i]) begin
               if ($urandom_range(0, 2) == 0) begin
                  r[i]  = 1'b1;
                  nd[i] = DW'($urandom);
               end
            end else if (m_g == i && !rdy && $urandom_range(0, 9) == 0) begin
               r[i] = 1'b0;
            end
         end
         drive(r, rdy, lk);
      end

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
